// File: rtl/onehot_seq_checker.sv
// Monitors a rotating one-hot word, tracks the expected next position and
// reports the decoded index, lock state, violations and completed cycles.
module onehot_seq_checker #(
  parameter int NBITS = 4,
  parameter int IDXW  = $clog2(NBITS),
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             restart,
  input  logic [NBITS-1:0] seq_in,
  output logic [IDXW-1:0]  index,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [CNTW-1:0]  err_count,
  output logic [CNTW-1:0]  wrap_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam logic [NBITS-1:0] FIRST   = NBITS'(1);
  localparam logic [NBITS-1:0] SECOND  = NBITS'(2);
  localparam logic [CNTW-1:0]  CNT_MAX = {CNTW{1'b1}};

  state_e           state_q, state_d;
  logic [NBITS-1:0] exp_q, exp_d;
  logic [IDXW-1:0]  index_q, index_d;
  logic             idx_valid_q, idx_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  err_count_q, err_count_d;
  logic [CNTW-1:0]  wrap_count_q, wrap_count_d;

  logic             is_onehot_s;
  logic [IDXW-1:0]  pos_s;
  logic             accept_s;

  // Classify the sample and encode the bit position of a one-hot word.
  always_comb begin
    is_onehot_s = (seq_in != '0) && ((seq_in & (seq_in - FIRST)) == '0);
    pos_s       = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (seq_in[i]) begin
        pos_s = IDXW'(i);
      end else begin
        pos_s = pos_s;
      end
    end
    if (restart) begin
      accept_s = (seq_in == FIRST);
    end else begin
      accept_s = is_onehot_s && (seq_in == exp_q);
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    index_d      = index_q;
    idx_valid_d  = 1'b0;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    if (valid) begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          // Both states wait silently for the start word.
          if (seq_in == FIRST) begin
            state_d     = ST_LOCKED;
            exp_d       = SECOND;
            index_d     = '0;
            idx_valid_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_LOCKED: begin
          if (accept_s) begin
            index_d     = pos_s;
            idx_valid_d = 1'b1;
            if (restart) begin
              exp_d = SECOND;
            end else begin
              exp_d = {exp_q[NBITS-2:0], exp_q[NBITS-1]};
            end
            if (seq_in[NBITS-1]) begin
              wrap_count_d = wrap_count_q + CNTW'(1);
            end else begin
              wrap_count_d = wrap_count_q;
            end
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNTW'(1);
            end else begin
              err_count_d = err_count_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          exp_d   = FIRST;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      exp_q        <= FIRST;
      index_q      <= '0;
      idx_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      index_q      <= index_d;
      idx_valid_q  <= idx_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign index      = index_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_onehot_seq_checker.sv
// Directed + random bench: a reference model pushes expected outputs into a
// queue at drive time; they are popped and compared one clock later.
module tb_onehot_seq_checker;

  logic       clk = 1'b0;
  logic       reset, valid, restart;
  logic [3:0] seq_in;
  logic [1:0] index_a, index_b;
  logic       idx_valid_a, locked_a, err_a, idx_valid_b, locked_b, err_b;
  logic [7:0] err_count_a, wrap_count_a;
  logic [1:0] err_count_b, wrap_count_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  onehot_seq_checker #(.NBITS(4)) dut_a (
    .clk(clk), .reset(reset), .valid(valid), .restart(restart), .seq_in(seq_in),
    .index(index_a), .idx_valid(idx_valid_a), .locked(locked_a), .err(err_a),
    .err_count(err_count_a), .wrap_count(wrap_count_a)
  );

  onehot_seq_checker #(.NBITS(4), .CNTW(2)) dut_b (
    .clk(clk), .reset(reset), .valid(valid), .restart(restart), .seq_in(seq_in),
    .index(index_b), .idx_valid(idx_valid_b), .locked(locked_b), .err(err_b),
    .err_count(err_count_b), .wrap_count(wrap_count_b)
  );

  typedef struct {
    logic [1:0] idx;
    logic       iv;
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [7:0] wc;
    logic [1:0] ec2;
    logic [1:0] wc2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int         m_st = 0;   // 0 idle, 1 locked, 2 error
  logic [3:0] m_exp = 4'b0001;
  exp_t       m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic rs, input logic [3:0] s);
    logic ok;
    m.iv = 1'b0;
    m.er = 1'b0;
    if (r) begin
      m_st = 0; m_exp = 4'b0001;
      m.idx = 2'd0; m.ec = 8'd0; m.wc = 8'd0; m.ec2 = 2'd0; m.wc2 = 2'd0;
    end else if (v) begin
      if (m_st == 1) begin
        ok = rs ? (s == 4'b0001) : (s == m_exp);
        if (ok) begin
          m.iv = 1'b1;
          case (s)
            4'b0001: m.idx = 2'd0;
            4'b0010: m.idx = 2'd1;
            4'b0100: m.idx = 2'd2;
            default: m.idx = 2'd3;
          endcase
          m_exp = rs ? 4'b0010 : {m_exp[2:0], m_exp[3]};
          if (s == 4'b1000) begin
            m.wc  = m.wc + 8'd1;
            m.wc2 = m.wc2 + 2'd1;
          end
        end else begin
          m_st = 2;
          m.er = 1'b1;
          if (m.ec  != 8'hFF)  m.ec  = m.ec + 8'd1;
          if (m.ec2 != 2'b11) m.ec2 = m.ec2 + 2'd1;
        end
      end else if (s == 4'b0001) begin
        m_st = 1; m_exp = 4'b0010; m.idx = 2'd0; m.iv = 1'b1;
      end
    end
    m.lk = (m_st == 1);
  endtask

  // Drive one cycle, queue the prediction, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic rs, input logic [3:0] s);
    exp_t e;
    @(negedge clk);
    reset = r; valid = v; restart = rs; seq_in = s;
    model(r, v, rs, s);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_empty: observed 0 expected 1");
    end else begin
      e = sb_q.pop_front();
      check("index",        32'(index_a),      32'(e.idx));
      check("idx_valid",    32'(idx_valid_a),  32'(e.iv));
      check("locked",       32'(locked_a),     32'(e.lk));
      check("err",          32'(err_a),        32'(e.er));
      check("err_count",    32'(err_count_a),  32'(e.ec));
      check("wrap_count",   32'(wrap_count_a), 32'(e.wc));
      check("err_count_c2", 32'(err_count_b),  32'(e.ec2));
      check("wrap_count_c2",32'(wrap_count_b), 32'(e.wc2));
      check("locked_c2",    32'(locked_b),     32'(e.lk));
      check("iv_err_excl",  32'(idx_valid_a & err_a), 32'(0));
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; restart = 1'b0; seq_in = 4'b0000;
    step(1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b0001);
    // Basic lock and a full cycle
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 1'b0, 4'b0100);
    step(1'b0, 1'b1, 1'b0, 4'b1000);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    check("direct_wrap1", 32'(wrap_count_a), 32'd1);
    check("direct_idx0",  32'(index_a),      32'd0);
    // Wrong position while expecting 0100
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 1'b0, 4'b1000);
    check("direct_err_pulse", 32'(err_a), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    check("direct_err_cnt1", 32'(err_count_a), 32'd1);
    check("direct_no_err",   32'(err_a),       32'd0);
    // Resync, then restart mid-sequence
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    check("direct_after_restart", 32'(index_a), 32'd1);
    // Multi-hot then resync
    step(1'b0, 1'b1, 1'b0, 4'b0110);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    // valid=0 cycles hold state, restart ignored
    step(1'b0, 1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    // Zero and restart-with-wrong-word violations
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b1, 4'b0010);
    // Saturate the 2-bit error counter
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'b0001);
      step(1'b0, 1'b1, 1'b0, 4'b1000);
    end
    check("direct_sat3", 32'(err_count_b), 32'd3);
    // Five full cycles for wrap roll-over on the narrow counter
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'b0010);
      step(1'b0, 1'b1, 1'b0, 4'b0100);
      step(1'b0, 1'b1, 1'b0, 4'b1000);
      step(1'b0, 1'b1, 1'b0, 4'b0001);
    end
    // Reset wins over a valid start word while locked
    step(1'b1, 1'b1, 1'b0, 4'b0001);
    check("direct_rst_locked", 32'(locked_a),    32'd0);
    check("direct_rst_iv",     32'(idx_valid_a), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'b0010);
    // Random traffic biased towards legal words
    for (int k = 0; k < 300; k++) begin
      logic [3:0] s;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)       s = m_exp;
      else if (sel == 6) s = 4'b0001;
      else               s = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 7) == 0), s);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
